// File: rtl/pwm_audio_out.sv
// PWM output stage for the mixed audio sample: one sample latched per PWM
// period, with a duty-cycle ramp for click-free mute and unmute.
module pwm_audio_out #(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] sample_in,
  input  logic       mute,
  output logic       pwm_out,
  output logic       sample_req,
  output logic [7:0] duty,
  output logic       muted
);

  localparam logic [1:0] ST_ACTIVE    = 2'd0;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd1;
  localparam logic [1:0] ST_MUTED     = 2'd2;
  localparam logic [1:0] ST_RAMP_UP   = 2'd3;

  localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);
  localparam logic [8:0] STEP9   = 9'(RAMP_STEP);

  logic [7:0] pre_cnt;
  logic [7:0] pwm_cnt;
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] duty_nxt;
  logic       tick;
  logic       boundary;

  logic [8:0] up_sum;
  logic       up_done;
  logic [7:0] up_val;
  logic [1:0] up_state;
  logic [7:0] down_val;
  logic [1:0] down_state;

  assign tick     = (pre_cnt == PRE_MAX);
  assign boundary = tick && (pwm_cnt == 8'd255);
  assign muted    = (state == ST_MUTED);

  // Ramp arithmetic is done in 9 bits so neither direction can wrap.
  assign up_sum     = {1'b0, duty} + STEP9;
  assign up_done    = (up_sum >= {1'b0, sample_in});
  assign up_val     = up_done ? sample_in : up_sum[7:0];
  assign up_state   = up_done ? ST_ACTIVE : ST_RAMP_UP;
  assign down_val   = ({1'b0, duty} > STEP9) ? 8'(({1'b0, duty} - STEP9)) : 8'd0;
  assign down_state = (down_val == 8'd0) ? ST_MUTED : ST_RAMP_DOWN;

  // Next duty/state, applied only at the period boundary.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    case (state)
      ST_ACTIVE: begin
        if (mute) begin
          duty_nxt  = down_val;
          state_nxt = down_state;
        end else begin
          duty_nxt  = sample_in;
        end
      end
      ST_RAMP_DOWN, ST_RAMP_UP: begin
        if (mute) begin
          duty_nxt  = down_val;
          state_nxt = down_state;
        end else begin
          duty_nxt  = up_val;
          state_nxt = up_state;
        end
      end
      default: begin
        if (mute) begin
          duty_nxt  = 8'd0;
          state_nxt = ST_MUTED;
        end else begin
          duty_nxt  = up_val;
          state_nxt = up_state;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pre_cnt    <= 8'd0;
      pwm_cnt    <= 8'd0;
      duty       <= 8'd0;
      state      <= ST_MUTED;
      pwm_out    <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      pre_cnt    <= tick ? 8'd0 : pre_cnt + 8'd1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      sample_req <= boundary;
      // Strict compare: duty 255 still leaves one low step per period.
      pwm_out    <= (pwm_cnt < duty);
      if (boundary) begin
        duty  <= duty_nxt;
        state <= state_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: directed boundary-by-boundary vectors with a
// scoreboard queue, plus a second instance at PRESCALE=3 checked free-running.
module tb_pwm_audio_out;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] sample_in;
  logic       mute;
  logic       pwm_out;
  logic       sample_req;
  logic [7:0] duty;
  logic       muted;

  logic [7:0] sample3 = 8'd128;
  logic       mute3   = 1'b0;
  logic       pwm3;
  logic       req3;
  logic [7:0] duty3;
  logic       muted3;

  int vectors     = 0;
  int miscompares = 0;
  bit aborted     = 1'b0;

  // Entry: {interval[11:0], muted, duty[7:0]}
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  pwm_audio_out #(.PRESCALE(1), .RAMP_STEP(4)) dut (
    .clk(clk), .nrst(nrst), .sample_in(sample_in), .mute(mute),
    .pwm_out(pwm_out), .sample_req(sample_req), .duty(duty), .muted(muted)
  );

  pwm_audio_out #(.PRESCALE(3), .RAMP_STEP(255)) dut3 (
    .clk(clk), .nrst(nrst), .sample_in(sample3), .mute(mute3),
    .pwm_out(pwm3), .sample_req(req3), .duty(duty3), .muted(muted3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present inputs for the next boundary, queue its expected result, and
  // wait until the corresponding sample_req has appeared.
  task automatic step(input logic [7:0] s, input logic m, input int ed,
                      input logic em, input int eint);
    int n;
    if (aborted) return;
    sample_in = s;
    mute      = m;
    exp_q.push_back({12'(eint), em, 8'(ed)});
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sample_req && n < 1000);
    if (!sample_req) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout: no sample_req after %0d clocks, expected within 1000", n);
      aborted = 1'b1;
    end
  endtask

  task automatic check_reset_values();
    check("rst_pwm_out", 32'(pwm_out), 0);
    check("rst_duty", 32'(duty), 0);
    check("rst_muted", 32'(muted), 1);
    check("rst_sample_req", 32'(sample_req), 0);
    check("rst_duty3", 32'(duty3), 0);
  endtask

  // Scoreboard monitor for the PRESCALE=1 instance.
  initial begin : monitor
    int          cyc;
    int          prev_duty;
    int          bit_err;
    logic [20:0] e;
    cyc = 0; prev_duty = 0; bit_err = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        cyc = 0; prev_duty = 0; bit_err = 0;
      end else begin
        cyc++;
        if (sample_req) begin
          check("req_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("duty", 32'(duty), 32'(e[7:0]));
            check("muted", 32'(muted), 32'(e[8]));
            check("interval", 32'(cyc), 32'(e[20:9]));
            check("window_bits", 32'(bit_err), 0);
            prev_duty = int'(e[7:0]);
          end
          cyc = 0;
          bit_err = 0;
        end
        if (pwm_out !== (cyc >= 1 && cyc <= prev_duty)) bit_err++;
      end
    end
  end

  // Free-running checks for the PRESCALE=3 instance (target 128 reached at once).
  initial begin : monitor3
    int cyc3;
    int seen;
    int bit_err3;
    int hi3;
    cyc3 = 0; seen = 0; bit_err3 = 0; hi3 = 0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        cyc3 = 0; seen = 0; bit_err3 = 0; hi3 = 0;
      end else begin
        cyc3++;
        if (req3) begin
          seen++;
          check("p3_interval", 32'(cyc3), (seen == 1) ? 769 : 768);
          check("p3_window_bits", 32'(bit_err3), 0);
          if (seen >= 2) check("p3_high_clocks", 32'(hi3), 384);
          check("p3_duty", 32'(duty3), 128);
          check("p3_muted", 32'(muted3), 0);
          cyc3 = 0; bit_err3 = 0; hi3 = 0;
        end
        if (pwm3) hi3++;
        if (pwm3 !== (seen >= 1 && cyc3 >= 1 && cyc3 <= 384)) bit_err3++;
      end
    end
  end

  initial begin : driver
    nrst = 1'b0;
    sample_in = 8'd0;
    mute = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      sample_in = 8'($urandom_range(0, 255));
      mute = 1'($urandom_range(0, 1));
    end
    check_reset_values();
    nrst = 1'b1;

    // Unmute ramp towards 200: 4, 8, ..., 200.
    step(200, 0, 4, 0, 257);
    for (int k = 2; k <= 50; k++) step(200, 0, 4 * k, 0, 256);

    // Steady duties, each held long enough for a full window check.
    step(64, 0, 64, 0, 256);
    step(64, 0, 64, 0, 256);
    step(0, 0, 0, 0, 256);
    step(0, 0, 0, 0, 256);
    step(255, 0, 255, 0, 256);
    step(255, 0, 255, 0, 256);

    // Mute from ACTIVE at duty 0 goes straight to MUTED.
    step(0, 0, 0, 0, 256);
    step(0, 1, 0, 1, 256);
    step(77, 1, 0, 1, 256);

    // Ramp up to 40, mute, ramp fully down to MUTED.
    for (int k = 1; k <= 10; k++) step(100, 0, 4 * k, 0, 256);
    for (int k = 1; k <= 9; k++) step(100, 1, 40 - 4 * k, 0, 256);
    step(100, 1, 0, 1, 256);

    // Up to 28, down to 20, unmute at 20 -> 24 and still ramping.
    for (int k = 1; k <= 7; k++) step(100, 0, 4 * k, 0, 256);
    step(100, 1, 24, 0, 256);
    step(100, 1, 20, 0, 256);
    step(100, 0, 24, 0, 256);
    step(100, 0, 28, 0, 256);
    // Target below current duty completes the ramp immediately.
    step(10, 0, 10, 0, 256);
    step(30, 0, 30, 0, 256);

    // ACTIVE -> RAMP_DOWN, back up, then ACTIVE small duty mutes directly.
    step(30, 1, 26, 0, 256);
    step(3, 0, 3, 0, 256);
    step(3, 1, 0, 1, 256);
    // Unmute with a silent target lands in ACTIVE at duty 0.
    step(0, 0, 0, 0, 256);
    step(150, 0, 150, 0, 256);
    step(150, 0, 150, 0, 256);

    // One-clock reset in the middle of a period.
    if (!aborted) begin
      repeat (100) @(posedge clk);
      #1;
      nrst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_values();
      nrst = 1'b1;
    end
    step(8, 0, 4, 0, 257);
    step(8, 0, 8, 0, 256);
    step(8, 0, 8, 0, 256);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
